// File: rtl/apb_ss_guard_pkg.sv
// Shared types and helpers for the APB subsystem guard.
package apb_ss_guard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        TOUT,
        ERR
    } guard_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Compared at 64 bits so base+size cannot wrap for any address up to 63 bits.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] size);
        return (addr >= base) && (addr < base + size);
    endfunction

endpackage

// File: rtl/apb_ss_guard_timer.sv
// Downstream access wait counter; expired marks the last allowed wait cycle.
module apb_ss_guard_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_ss_guard.sv
// APB protection stage in front of one subsystem: window/enable check and PREADY timeout.
// Optional feature macro: APB_SS_GUARD_STATS_EN (saturating timeout counter).
module apb_ss_guard
    import apb_ss_guard_pkg::*;
#(
    parameter int unsigned       APB_AW         = 32,
    parameter int unsigned       APB_DW         = 32,
    parameter int unsigned       SS_CTRL_W      = 7,
    parameter logic [APB_AW-1:0] ADDR_BASE      = APB_AW'(32'h0105_0000),
    parameter logic [APB_AW-1:0] SS_SIZE        = APB_AW'(32'h1000),
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [APB_DW-1:0] ERR_RDATA      = APB_DW'(ERR_RDATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SS_CTRL_W-1:0]  ss_ctrl,
    input  logic                  clear_status,

    input  logic [APB_AW-1:0]     S_PADDR,
    input  logic                  S_PSEL,
    input  logic                  S_PENABLE,
    input  logic                  S_PWRITE,
    input  logic [APB_DW-1:0]     S_PWDATA,
    input  logic [APB_DW/8-1:0]   S_PSTRB,
    output logic [APB_DW-1:0]     S_PRDATA,
    output logic                  S_PREADY,
    output logic                  S_PSLVERR,

    output logic [APB_AW-1:0]     M_PADDR,
    output logic                  M_PSEL,
    output logic                  M_PENABLE,
    output logic                  M_PWRITE,
    output logic [APB_DW-1:0]     M_PWDATA,
    output logic [APB_DW/8-1:0]   M_PSTRB,
    input  logic [APB_DW-1:0]     M_PRDATA,
    input  logic                  M_PREADY,
    input  logic                  M_PSLVERR,

    output logic                  timeout_flag,
    output logic [15:0]           timeout_count
);

    guard_state_e state_q, state_d;

    logic [APB_AW-1:0]   m_paddr_q, m_paddr_d;
    logic                m_psel_q, m_psel_d;
    logic                m_penable_q, m_penable_d;
    logic                m_pwrite_q, m_pwrite_d;
    logic [APB_DW-1:0]   m_pwdata_q, m_pwdata_d;
    logic [APB_DW/8-1:0] m_pstrb_q, m_pstrb_d;
    logic [APB_DW-1:0]   s_prdata_q, s_prdata_d;
    logic                s_pready_q, s_pready_d;
    logic                s_pslverr_q, s_pslverr_d;
    logic                timeout_flag_q, timeout_flag_d;

    logic addr_ok;
    logic tmr_clr, tmr_run, tmr_expired;
    logic tout_evt;
    logic ctrl_unused;

    assign ctrl_unused = ^ss_ctrl[SS_CTRL_W-1:1];
    assign addr_ok     = in_window(64'(S_PADDR), 64'(ADDR_BASE), 64'(SS_SIZE));
    assign tout_evt    = (state_d == TOUT);

    apb_ss_guard_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (S_PSEL && !S_PENABLE) begin
                    state_d = (ss_ctrl[0] && addr_ok) ? SETUP : ERR;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                tmr_clr = 1'b1;
            end
            ACCESS: begin
                if (M_PREADY) begin
                    state_d = RESP;
                end else if (tmr_expired) begin
                    state_d = TOUT;
                end else begin
                    tmr_run = 1'b1;
                end
            end
            RESP, TOUT, ERR: state_d = IDLE;
            default:         state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        m_paddr_d   = m_paddr_q;
        m_pwrite_d  = m_pwrite_q;
        m_pwdata_d  = m_pwdata_q;
        m_pstrb_d   = m_pstrb_q;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
        s_pready_d  = 1'b0;
        s_pslverr_d = 1'b0;
        s_prdata_d  = '0;

        if (state_q == IDLE && state_d == SETUP) begin
            m_paddr_d  = S_PADDR;
            m_pwrite_d = S_PWRITE;
            m_pwdata_d = S_PWDATA;
            m_pstrb_d  = S_PSTRB;
        end

        case (state_d)
            SETUP: begin
                m_psel_d = 1'b1;
            end
            ACCESS: begin
                m_psel_d    = 1'b1;
                m_penable_d = 1'b1;
            end
            RESP: begin
                s_pready_d  = 1'b1;
                s_pslverr_d = M_PSLVERR;
                s_prdata_d  = m_pwrite_q ? '0 : M_PRDATA;
            end
            TOUT, ERR: begin
                s_pready_d  = 1'b1;
                s_pslverr_d = 1'b1;
                s_prdata_d  = ERR_RDATA;
            end
            default: ;
        endcase
    end

    // A timeout in the same cycle as clear_status leaves the flag set.
    always_comb begin
        timeout_flag_d = timeout_flag_q;
        if (clear_status) begin
            timeout_flag_d = 1'b0;
        end
        if (tout_evt) begin
            timeout_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_paddr_q      <= '0;
            m_psel_q       <= 1'b0;
            m_penable_q    <= 1'b0;
            m_pwrite_q     <= 1'b0;
            m_pwdata_q     <= '0;
            m_pstrb_q      <= '0;
            s_prdata_q     <= '0;
            s_pready_q     <= 1'b0;
            s_pslverr_q    <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            m_paddr_q      <= m_paddr_d;
            m_psel_q       <= m_psel_d;
            m_penable_q    <= m_penable_d;
            m_pwrite_q     <= m_pwrite_d;
            m_pwdata_q     <= m_pwdata_d;
            m_pstrb_q      <= m_pstrb_d;
            s_prdata_q     <= s_prdata_d;
            s_pready_q     <= s_pready_d;
            s_pslverr_q    <= s_pslverr_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

`ifdef APB_SS_GUARD_STATS_EN
    logic [15:0] timeout_count_q, timeout_count_d;

    always_comb begin
        timeout_count_d = timeout_count_q;
        if (tout_evt && clear_status) begin
            timeout_count_d = 16'd1;
        end else if (clear_status) begin
            timeout_count_d = '0;
        end else if (tout_evt && timeout_count_q != 16'hFFFF) begin
            timeout_count_d = timeout_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_count_q <= '0;
        end else begin
            timeout_count_q <= timeout_count_d;
        end
    end

    assign timeout_count = timeout_count_q;
`else
    assign timeout_count = '0;
`endif

    assign M_PADDR      = m_paddr_q;
    assign M_PSEL       = m_psel_q;
    assign M_PENABLE    = m_penable_q;
    assign M_PWRITE     = m_pwrite_q;
    assign M_PWDATA     = m_pwdata_q;
    assign M_PSTRB      = m_pstrb_q;
    assign S_PRDATA     = s_prdata_q;
    assign S_PREADY     = s_pready_q;
    assign S_PSLVERR    = s_pslverr_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_apb_ss_guard.sv
// Directed scoreboard bench for apb_ss_guard (TIMEOUT_CYCLES=4); honours APB_SS_GUARD_STATS_EN.
module tb_apb_ss_guard;

`ifdef APB_SS_GUARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [6:0]  ss_ctrl;
    logic        clear_status;
    logic [31:0] S_PADDR;
    logic        S_PSEL;
    logic        S_PENABLE;
    logic        S_PWRITE;
    logic [31:0] S_PWDATA;
    logic [3:0]  S_PSTRB;
    logic [31:0] S_PRDATA;
    logic        S_PREADY;
    logic        S_PSLVERR;
    logic [31:0] M_PADDR;
    logic        M_PSEL;
    logic        M_PENABLE;
    logic        M_PWRITE;
    logic [31:0] M_PWDATA;
    logic [3:0]  M_PSTRB;
    logic [31:0] M_PRDATA;
    logic        M_PREADY;
    logic        M_PSLVERR;
    logic        timeout_flag;
    logic [15:0] timeout_count;

    apb_ss_guard #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ss_ctrl       (ss_ctrl),
        .clear_status  (clear_status),
        .S_PADDR       (S_PADDR),
        .S_PSEL        (S_PSEL),
        .S_PENABLE     (S_PENABLE),
        .S_PWRITE      (S_PWRITE),
        .S_PWDATA      (S_PWDATA),
        .S_PSTRB       (S_PSTRB),
        .S_PRDATA      (S_PRDATA),
        .S_PREADY      (S_PREADY),
        .S_PSLVERR     (S_PSLVERR),
        .M_PADDR       (M_PADDR),
        .M_PSEL        (M_PSEL),
        .M_PENABLE     (M_PENABLE),
        .M_PWRITE      (M_PWRITE),
        .M_PWDATA      (M_PWDATA),
        .M_PSTRB       (M_PSTRB),
        .M_PRDATA      (M_PRDATA),
        .M_PREADY      (M_PREADY),
        .M_PSLVERR     (M_PSLVERR),
        .timeout_flag  (timeout_flag),
        .timeout_count (timeout_count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    int          slv_waits;
    bit          slv_never;
    logic [31:0] slv_rdata;
    logic        slv_err;

    bit          last_seen_psel;
    int          last_pen_cycles;
    logic [31:0] last_mpaddr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    // Downstream slave: raises PREADY after slv_waits access cycles unless slv_never.
    initial begin
        int wcnt;
        wcnt      = 0;
        M_PREADY  = 1'b0;
        M_PRDATA  = '0;
        M_PSLVERR = 1'b0;
        forever begin
            @(negedge clk);
            if (M_PSEL && M_PENABLE) begin
                if (!slv_never && wcnt == slv_waits) begin
                    M_PREADY  = 1'b1;
                    M_PRDATA  = slv_rdata;
                    M_PSLVERR = slv_err;
                end else begin
                    M_PREADY  = 1'b0;
                    M_PRDATA  = '0;
                    M_PSLVERR = 1'b0;
                    wcnt++;
                end
            end else begin
                M_PREADY  = 1'b0;
                M_PRDATA  = '0;
                M_PSLVERR = 1'b0;
                wcnt      = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One upstream transfer; expected response is queued at drive time and popped at S_PREADY.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int clr_lat);
        exp_t e;
        int   lat;
        bit   got;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        S_PSEL    = 1'b1;
        S_PENABLE = 1'b0;
        S_PADDR   = addr;
        S_PWRITE  = wr;
        S_PWDATA  = wdata;
        S_PSTRB   = 4'hF;
        lat = 0;
        got = 1'b0;
        last_seen_psel  = 1'b0;
        last_pen_cycles = 0;
        last_mpaddr     = '0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            S_PENABLE    = 1'b1;
            clear_status = (lat == clr_lat);
            if (M_PSEL) begin
                last_seen_psel = 1'b1;
                last_mpaddr    = M_PADDR;
            end
            if (M_PENABLE) last_pen_cycles++;
            if (S_PREADY) got = 1'b1;
        end
        clear_status = 1'b0;
        e = sb.pop_front();
        chk("resp_seen", 64'(got), 64'(1));
        chk("latency",   64'(lat), 64'(e.lat));
        chk("prdata",    64'(S_PRDATA), 64'(e.rdata));
        chk("pslverr",   64'(S_PSLVERR), 64'(e.err));
        S_PSEL    = 1'b0;
        S_PENABLE = 1'b0;
        @(negedge clk);
        chk("pready_one_cycle", 64'(S_PREADY), 64'(0));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        ss_ctrl      = 7'h01;
        clear_status = 1'b0;
        S_PADDR      = '0;
        S_PSEL       = 1'b0;
        S_PENABLE    = 1'b0;
        S_PWRITE     = 1'b0;
        S_PWDATA     = '0;
        S_PSTRB      = '0;
        slv_waits    = 0;
        slv_never    = 1'b0;
        slv_rdata    = '0;
        slv_err      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_pready",  64'(S_PREADY), 64'(0));
        chk("rst_s_pslverr", 64'(S_PSLVERR), 64'(0));
        chk("rst_s_prdata",  64'(S_PRDATA), 64'(0));
        chk("rst_m_psel",    64'(M_PSEL), 64'(0));
        chk("rst_m_penable", 64'(M_PENABLE), 64'(0));
        chk("rst_m_paddr",   64'(M_PADDR), 64'(0));
        chk("rst_flag",      64'(timeout_flag), 64'(0));
        chk("rst_count",     64'(timeout_count), 64'(0));
        reset_n = 1'b1;

        // Zero-wait read forwarded
        slv_waits = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
        xfer(32'h0105_0010, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, 0);
        chk("t1_mpaddr", 64'(last_mpaddr), 64'(32'h0105_0010));
        chk("t1_pen_cycles", 64'(last_pen_cycles), 64'(1));

        // Disabled subsystem
        ss_ctrl = 7'h7E;
        xfer(32'h0105_0000, 1'b1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b1, 1, 0);
        chk("t2_no_m_psel", 64'(last_seen_psel), 64'(0));

        // Window boundaries
        ss_ctrl = 7'h01;
        xfer(32'h0105_1000, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0);
        chk("t3_hi_no_m_psel", 64'(last_seen_psel), 64'(0));
        xfer(32'h0104_FFFC, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0);
        xfer(32'h0105_0FFC, 1'b1, 32'h1111_2222, 32'h0, 1'b0, 3, 0);
        chk("t3_mpaddr_top", 64'(last_mpaddr), 64'(32'h0105_0FFC));
        chk("t3_mpwdata", 64'(M_PWDATA), 64'(32'h1111_2222));
        chk("t3_mpwrite", 64'(M_PWRITE), 64'(1));
        xfer(32'h0105_0000, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, 0);
        chk("t3_mpaddr_base", 64'(last_mpaddr), 64'(32'h0105_0000));

        // Timeouts
        slv_never = 1'b1;
        xfer(32'h0105_0020, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 6, 0);
        chk("t4_pen_cycles", 64'(last_pen_cycles), 64'(4));
        chk("t4_flag", 64'(timeout_flag), 64'(1));
        chk("t4_count1", 64'(timeout_count), STATS ? 64'(1) : 64'(0));
        xfer(32'h0105_0024, 1'b1, 32'h5, 32'hDEAD_BEEF, 1'b1, 6, 0);
        chk("t4_count2", 64'(timeout_count), STATS ? 64'(2) : 64'(0));
        xfer(32'h0105_0028, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 6, 5);
        chk("t4_clr_tout_flag", 64'(timeout_flag), 64'(1));
        chk("t4_clr_tout_count", 64'(timeout_count), STATS ? 64'(1) : 64'(0));
        pulse_clear();
        chk("t4_cleared_flag", 64'(timeout_flag), 64'(0));
        chk("t4_cleared_count", 64'(timeout_count), 64'(0));

        // Reset while in ACCESS
        @(negedge clk);
        S_PSEL = 1'b1; S_PENABLE = 1'b0; S_PADDR = 32'h0105_0040; S_PWRITE = 1'b0;
        @(negedge clk);
        S_PENABLE = 1'b1;
        @(negedge clk);
        chk("t5_in_access", 64'(M_PENABLE), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_m_psel", 64'(M_PSEL), 64'(0));
        chk("t5_m_penable", 64'(M_PENABLE), 64'(0));
        chk("t5_s_pready", 64'(S_PREADY), 64'(0));
        chk("t5_m_paddr", 64'(M_PADDR), 64'(0));
        reset_n = 1'b1; S_PSEL = 1'b0; S_PENABLE = 1'b0; slv_never = 1'b0;
        slv_waits = 0; slv_rdata = 32'hCAFE_0005;
        xfer(32'h0105_0044, 1'b0, 32'h0, 32'hCAFE_0005, 1'b0, 3, 0);

        // Slave error on a write after 3 waits
        slv_waits = 3; slv_rdata = 32'h7777_7777; slv_err = 1'b1;
        xfer(32'h0105_0100, 1'b1, 32'hFACE_0001, 32'h0, 1'b1, 6, 0);
        chk("t6_pen_cycles", 64'(last_pen_cycles), 64'(4));
        chk("t6_flag", 64'(timeout_flag), 64'(0));
        chk("t6_count", 64'(timeout_count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
